// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-client RAM arbiter: client count,
// client index constants and the last-winner pointer type.
package ram_arb_pkg;

   localparam int NUM_CLIENTS = 2;

   // A pointer names one client, so it is one client index wide.
   typedef logic [$clog2(NUM_CLIENTS)-1:0] client_ptr_t;

   localparam client_ptr_t CLIENT_0 = 1'b0;
   localparam client_ptr_t CLIENT_1 = 1'b1;

   // Converts a one-hot two-client grant into the index of the winner.
   function automatic client_ptr_t grantToIndex(input logic [NUM_CLIENTS-1:0] grant);
      return grant[1] ? CLIENT_1 : CLIENT_0;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way pick: turns a 2-bit request vector and the last-winner pointer
// into a one-hot grant. On a tie the client that did not win last time
// is chosen; a lone requester is always chosen.
module rr_pick2
   import ram_arb_pkg::*;
(
   input  logic [NUM_CLIENTS-1:0] i_req,
   input  client_ptr_t            i_lastWinner,
   output logic [NUM_CLIENTS-1:0] o_grant
);

   // Resolve ties against the previous winner, pass single requests through.
   always_comb begin
      o_grant = '0;
      if (i_req == 2'b11) begin
         o_grant = (i_lastWinner == CLIENT_0) ? 2'b10 : 2'b01;
      end else begin
         o_grant = i_req;
      end
   end

endmodule

// File: rtl/ram_arbiter_2c.sv
// Two-client arbiter in front of a RAM with one read and one write port.
// Reads and writes are arbitrated independently with combinational grants;
// read data comes back one cycle after its grant on a shared bus tagged by
// a one-hot valid.
// Configuration macro RAM_ARB_ROUND_ROBIN_EN: when defined, ties are broken
// round-robin with separate read/write last-winner pointers; when undefined,
// client 0 always wins ties and no pointer state exists.
module ram_arbiter_2c
   import ram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
)
(
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [1:0]            iReadReq,
   input  logic [ADDR_WIDTH-1:0] iReadAddr0,
   input  logic [ADDR_WIDTH-1:0] iReadAddr1,
   output logic [1:0]            oReadGrant,
   output logic [1:0]            oReadValid,
   output logic [DATA_WIDTH-1:0] oReadData,
   input  logic [1:0]            iWriteReq,
   input  logic [ADDR_WIDTH-1:0] iWriteAddr0,
   input  logic [ADDR_WIDTH-1:0] iWriteAddr1,
   input  logic [DATA_WIDTH-1:0] iWriteData0,
   input  logic [DATA_WIDTH-1:0] iWriteData1,
   output logic [1:0]            oWriteGrant,
   output logic                  oRamWriteEnable,
   output logic [ADDR_WIDTH-1:0] oRamWriteAddress,
   output logic [DATA_WIDTH-1:0] oRamDataIn,
   output logic [ADDR_WIDTH-1:0] oRamReadAddress,
   input  logic [DATA_WIDTH-1:0] iRamDataOut
);

   client_ptr_t           w_readPtr;
   client_ptr_t           w_writePtr;
   logic [1:0]            w_readPick;
   logic [1:0]            w_writePick;
   logic [1:0]            w_readGrant;
   logic [1:0]            w_writeGrant;
   logic [ADDR_WIDTH-1:0] w_readAddrSel;
   logic [ADDR_WIDTH-1:0] r_readAddrHold;
   logic [1:0]            r_readValid;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   client_ptr_t r_readLast;
   client_ptr_t r_writeLast;

   // Remember the last read and write winners; reset so client 0 wins the first tie.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_readLast  <= CLIENT_1;
         r_writeLast <= CLIENT_1;
      end else begin
         if (|w_readGrant) begin
            r_readLast <= grantToIndex(w_readGrant);
         end
         if (|w_writeGrant) begin
            r_writeLast <= grantToIndex(w_writeGrant);
         end
      end
   end

   assign w_readPtr  = r_readLast;
   assign w_writePtr = r_writeLast;
`else
   // Fixed priority: a permanent "client 1 won last" makes client 0 win every tie.
   assign w_readPtr  = CLIENT_1;
   assign w_writePtr = CLIENT_1;
`endif

   rr_pick2 u_readPick (
      .i_req        (iReadReq),
      .i_lastWinner (w_readPtr),
      .o_grant      (w_readPick)
   );

   rr_pick2 u_writePick (
      .i_req        (iWriteReq),
      .i_lastWinner (w_writePtr),
      .o_grant      (w_writePick)
   );

   // Requests seen during reset are dropped rather than granted or queued.
   assign w_readGrant  = Reset ? 2'b00 : w_readPick;
   assign w_writeGrant = Reset ? 2'b00 : w_writePick;

   assign oReadGrant  = w_readGrant;
   assign oWriteGrant = w_writeGrant;

   assign w_readAddrSel = w_readGrant[1] ? iReadAddr1 : iReadAddr0;

   // Keep the last granted read address so the RAM address is stable when idle,
   // and track which client owns the data returning next cycle.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_readAddrHold <= '0;
         r_readValid    <= 2'b00;
      end else begin
         if (|w_readGrant) begin
            r_readAddrHold <= w_readAddrSel;
         end
         r_readValid <= w_readGrant;
      end
   end

   // A read granted just before reset must not report valid data during reset.
   assign oReadValid      = Reset ? 2'b00 : r_readValid;
   assign oReadData       = Reset ? '0 : iRamDataOut;
   assign oRamReadAddress = Reset ? '0 :
                            ((|w_readGrant) ? w_readAddrSel : r_readAddrHold);

   // Write path is purely combinational: the granted client drives the RAM this cycle.
   always_comb begin
      oRamWriteEnable  = 1'b0;
      oRamWriteAddress = '0;
      oRamDataIn       = '0;
      if (w_writeGrant[0]) begin
         oRamWriteEnable  = 1'b1;
         oRamWriteAddress = iWriteAddr0;
         oRamDataIn       = iWriteData0;
      end else if (w_writeGrant[1]) begin
         oRamWriteEnable  = 1'b1;
         oRamWriteAddress = iWriteAddr1;
         oRamDataIn       = iWriteData1;
      end
   end

endmodule

// File: tb/tb_ram_arbiter_2c.sv
// Self-checking bench for ram_arbiter_2c with a behavioural registered-read
// RAM attached. Expectations follow RAM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_ram_arbiter_2c;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   localparam bit RoundRobin = 1'b1;
`else
   localparam bit RoundRobin = 1'b0;
`endif

   typedef struct {
      logic       reset;
      logic [1:0] rReq;
      logic [1:0] wReq;
      logic [9:0] ra0;
      logic [9:0] ra1;
      logic [9:0] wa0;
      logic [9:0] wa1;
      logic [7:0] wd0;
      logic [7:0] wd1;
      logic [1:0] eRG;
      logic [1:0] eWG;
      logic       eWE;
      logic [9:0] eWA;
      logic [7:0] eDin;
      logic [9:0] eRA;
      logic [1:0] eRV;
      logic [7:0] eRD;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] iReadReq;
   logic [9:0] iReadAddr0, iReadAddr1;
   logic [1:0] oReadGrant, oReadValid;
   logic [7:0] oReadData;
   logic [1:0] iWriteReq;
   logic [9:0] iWriteAddr0, iWriteAddr1;
   logic [7:0] iWriteData0, iWriteData1;
   logic [1:0] oWriteGrant;
   logic       oRamWriteEnable;
   logic [9:0] oRamWriteAddress;
   logic [7:0] oRamDataIn;
   logic [9:0] oRamReadAddress;
   logic [7:0] ramDataOut = 8'h00;
   logic       memReady = 1'b0;
   logic [7:0] mem [0:1023];

   int compared = 0;
   int mismatched = 0;

   vec_t vecs [12];

   always #5 clock = ~clock;

   ram_arbiter_2c dut (
      .Clock            (clock),
      .Reset            (reset),
      .iReadReq         (iReadReq),
      .iReadAddr0       (iReadAddr0),
      .iReadAddr1       (iReadAddr1),
      .oReadGrant       (oReadGrant),
      .oReadValid       (oReadValid),
      .oReadData        (oReadData),
      .iWriteReq        (iWriteReq),
      .iWriteAddr0      (iWriteAddr0),
      .iWriteAddr1      (iWriteAddr1),
      .iWriteData0      (iWriteData0),
      .iWriteData1      (iWriteData1),
      .oWriteGrant      (oWriteGrant),
      .oRamWriteEnable  (oRamWriteEnable),
      .oRamWriteAddress (oRamWriteAddress),
      .oRamDataIn       (oRamDataIn),
      .oRamReadAddress  (oRamReadAddress),
      .iRamDataOut      (ramDataOut)
   );

   // Behavioural RAM: write-first-edge clears it, then registered read with old-data on collision.
   always @(posedge clock) begin
      if (!memReady) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
         memReady <= 1'b1;
      end else begin
         if (oRamWriteEnable) mem[oRamWriteAddress] <= oRamDataIn;
         ramDataOut <= mem[oRamReadAddress];
      end
   end

   function automatic vec_t idleVec();
      vec_t v;
      v = '{1'b0, 2'b00, 2'b00, 10'h0, 10'h0, 10'h0, 10'h0, 8'h00, 8'h00,
            2'b00, 2'b00, 1'b0, 10'h0, 8'h00, 10'h0, 2'b00, 8'h00};
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Drives one cycle of inputs just after the rising edge, then waits to the falling edge.
   task automatic applyStimulus(input vec_t v);
      @(posedge clock);
      #1;
      reset       = v.reset;
      iReadReq    = v.rReq;
      iWriteReq   = v.wReq;
      iReadAddr0  = v.ra0;
      iReadAddr1  = v.ra1;
      iWriteAddr0 = v.wa0;
      iWriteAddr1 = v.wa1;
      iWriteData0 = v.wd0;
      iWriteData1 = v.wd1;
      @(negedge clock);
   endtask

   initial begin
      vec_t v;
      logic [1:0] prevG;
      logic [1:0] expG;

      reset = 1'b1;
      iReadReq = 2'b00; iWriteReq = 2'b00;
      iReadAddr0 = '0; iReadAddr1 = '0; iWriteAddr0 = '0; iWriteAddr1 = '0;
      iWriteData0 = '0; iWriteData1 = '0;

      //          rst  rReq   wReq   ra0     ra1     wa0     wa1     wd0    wd1     eRG    eWG   eWE  eWA     eDin   eRA     eRV    eRD
      vecs[0]  = '{1'b1, 2'b11, 2'b11, 10'h003, 10'h005, 10'h007, 10'h009, 8'h11, 8'h22, 2'b00, 2'b00, 1'b0, 10'h000, 8'h00, 10'h000, 2'b00, 8'h00};
      vecs[1]  = '{1'b1, 2'b11, 2'b11, 10'h003, 10'h005, 10'h007, 10'h009, 8'h11, 8'h22, 2'b00, 2'b00, 1'b0, 10'h000, 8'h00, 10'h000, 2'b00, 8'h00};
      vecs[2]  = '{1'b0, 2'b00, 2'b01, 10'h000, 10'h000, 10'h003, 10'h000, 8'hA5, 8'h00, 2'b00, 2'b01, 1'b1, 10'h003, 8'hA5, 10'h000, 2'b00, 8'h00};
      vecs[3]  = '{1'b0, 2'b10, 2'b00, 10'h000, 10'h003, 10'h000, 10'h000, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0, 10'h000, 8'h00, 10'h003, 2'b00, 8'h00};
      vecs[4]  = '{1'b0, 2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 10'h000, 8'h00, 10'h003, 2'b10, 8'hA5};
      vecs[5]  = '{1'b0, 2'b10, 2'b01, 10'h000, 10'h010, 10'h010, 10'h000, 8'h3C, 8'h00, 2'b10, 2'b01, 1'b1, 10'h010, 8'h3C, 10'h010, 2'b00, 8'h00};
      vecs[6]  = '{1'b0, 2'b10, 2'b00, 10'h000, 10'h010, 10'h000, 10'h000, 8'h00, 8'h00, 2'b10, 2'b00, 1'b0, 10'h000, 8'h00, 10'h010, 2'b10, 8'h00};
      vecs[7]  = '{1'b0, 2'b01, 2'b00, 10'h020, 10'h000, 10'h000, 10'h000, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0, 10'h000, 8'h00, 10'h020, 2'b10, 8'h3C};
      vecs[8]  = '{1'b0, 2'b00, 2'b10, 10'h000, 10'h000, 10'h000, 10'h055, 8'h00, 8'h77, 2'b00, 2'b10, 1'b1, 10'h055, 8'h77, 10'h020, 2'b01, 8'h00};
      vecs[9]  = '{1'b0, 2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 10'h000, 8'h00, 10'h020, 2'b00, 8'h00};
      vecs[10] = '{1'b0, 2'b01, 2'b00, 10'h055, 10'h000, 10'h000, 10'h000, 8'h00, 8'h00, 2'b01, 2'b00, 1'b0, 10'h000, 8'h00, 10'h055, 2'b00, 8'h00};
      vecs[11] = '{1'b0, 2'b00, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 10'h000, 8'h00, 10'h055, 2'b01, 8'h77};

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("row%0d readGrant", i), 32'(oReadGrant), 32'(vecs[i].eRG));
         checkOutput($sformatf("row%0d writeGrant", i), 32'(oWriteGrant), 32'(vecs[i].eWG));
         checkOutput($sformatf("row%0d writeEnable", i), 32'(oRamWriteEnable), 32'(vecs[i].eWE));
         checkOutput($sformatf("row%0d writeAddr", i), 32'(oRamWriteAddress), 32'(vecs[i].eWA));
         checkOutput($sformatf("row%0d dataIn", i), 32'(oRamDataIn), 32'(vecs[i].eDin));
         checkOutput($sformatf("row%0d readAddr", i), 32'(oRamReadAddress), 32'(vecs[i].eRA));
         checkOutput($sformatf("row%0d readValid", i), 32'(oReadValid), 32'(vecs[i].eRV));
         if (vecs[i].reset || vecs[i].eRV != 2'b00)
            checkOutput($sformatf("row%0d readData", i), 32'(oReadData), 32'(vecs[i].eRD));
      end

      // Read granted, then reset in the following cycle: no valid, everything zero.
      v = idleVec();
      v.rReq = 2'b01; v.ra0 = 10'h003;
      applyStimulus(v);
      checkOutput("preReset readGrant", 32'(oReadGrant), 32'h1);
      checkOutput("preReset readAddr", 32'(oRamReadAddress), 32'h003);
      v = idleVec();
      v.reset = 1'b1; v.rReq = 2'b11; v.wReq = 2'b11;
      v.ra0 = 10'h003; v.ra1 = 10'h010; v.wa0 = 10'h100; v.wa1 = 10'h101; v.wd0 = 8'h11; v.wd1 = 8'h22;
      applyStimulus(v);
      checkOutput("inReset readValid", 32'(oReadValid), 32'h0);
      checkOutput("inReset readGrant", 32'(oReadGrant), 32'h0);
      checkOutput("inReset writeGrant", 32'(oWriteGrant), 32'h0);
      checkOutput("inReset writeEnable", 32'(oRamWriteEnable), 32'h0);
      checkOutput("inReset readAddr", 32'(oRamReadAddress), 32'h0);
      checkOutput("inReset writeAddr", 32'(oRamWriteAddress), 32'h0);
      checkOutput("inReset dataIn", 32'(oRamDataIn), 32'h0);
      checkOutput("inReset readData", 32'(oReadData), 32'h0);

      // Both clients read for 6 cycles straight after reset release.
      prevG = 2'b00;
      for (int k = 0; k < 6; k++) begin
         v = idleVec();
         v.rReq = 2'b11; v.ra0 = 10'h003; v.ra1 = 10'h010;
         applyStimulus(v);
         expG = (RoundRobin && (k % 2 == 1)) ? 2'b10 : 2'b01;
         checkOutput($sformatf("tie%0d readGrant", k), 32'(oReadGrant), 32'(expG));
         checkOutput($sformatf("tie%0d readValid", k), 32'(oReadValid), 32'(prevG));
         if (prevG != 2'b00)
            checkOutput($sformatf("tie%0d readData", k), 32'(oReadData), (prevG == 2'b01) ? 32'hA5 : 32'h3C);
         prevG = expG;
      end
      v = idleVec();
      applyStimulus(v);
      checkOutput("tieTail readValid", 32'(oReadValid), 32'(prevG));
      checkOutput("tieTail readData", 32'(oReadData), (prevG == 2'b01) ? 32'hA5 : 32'h3C);

      // Both clients write for 2 cycles; write pointer was reset above.
      for (int k = 0; k < 2; k++) begin
         v = idleVec();
         v.wReq = 2'b11; v.wa0 = 10'h100; v.wa1 = 10'h101; v.wd0 = 8'h11; v.wd1 = 8'h22;
         applyStimulus(v);
         expG = (RoundRobin && k == 1) ? 2'b10 : 2'b01;
         checkOutput($sformatf("wtie%0d writeGrant", k), 32'(oWriteGrant), 32'(expG));
         checkOutput($sformatf("wtie%0d writeAddr", k), 32'(oRamWriteAddress), (expG == 2'b01) ? 32'h100 : 32'h101);
         checkOutput($sformatf("wtie%0d dataIn", k), 32'(oRamDataIn), (expG == 2'b01) ? 32'h11 : 32'h22);
      end

      // A lone requester wins every cycle regardless of pointer state.
      for (int k = 0; k < 2; k++) begin
         v = idleVec();
         v.rReq = 2'b10; v.ra1 = 10'h010;
         applyStimulus(v);
         checkOutput($sformatf("solo%0d readGrant", k), 32'(oReadGrant), 32'h2);
         checkOutput($sformatf("solo%0d readAddr", k), 32'(oRamReadAddress), 32'h010);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/ram_arbiter_2c.md
RAM_ARBITER_2C -- requirements
Module: ram_arbiter_2c

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 8, as the RAM word width.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 10, as the RAM address width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
- Clock  in  1  rising-edge clock for all state
- Reset  in  1  synchronous reset, active-high
- iReadReq  in  2  per-client read request, held until granted
- iReadAddr0 / iReadAddr1  in  ADDR_WIDTH each  client read address
- oReadGrant  out  2  one-hot read grant, combinational, same cycle as request
- oReadValid  out  2  one-hot, marks oReadData as belonging to that client
- oReadData  out  DATA_WIDTH  shared read-return bus
- iWriteReq  in  2  per-client write request, held until granted
- iWriteAddr0 / iWriteAddr1  in  ADDR_WIDTH each  client write address
- iWriteData0 / iWriteData1  in  DATA_WIDTH each  client write data
- oWriteGrant  out  2  one-hot write grant, combinational
- oRamWriteEnable  out  1  drives the RAM write enable
- oRamWriteAddress  out  ADDR_WIDTH  RAM write address
- oRamDataIn  out  DATA_WIDTH  RAM write data
- oRamReadAddress  out  ADDR_WIDTH  RAM read address
- iRamDataOut  in  DATA_WIDTH  RAM registered read data, valid one cycle after its address

Function
REQ-004 Read and write arbitration SHALL be independent; at most one read grant and one write grant per cycle.
REQ-005 A grant SHALL complete a transfer: request high and grant high in the same cycle means the transfer is accepted. An ungranted client SHALL hold its request, address and data.
REQ-006 The granted read address SHALL drive oRamReadAddress in the grant cycle. oRamReadAddress SHALL hold its last value when no read is granted.
REQ-007 oReadValid[i] SHALL assert exactly one cycle after oReadGrant[i]. In that cycle oReadData SHALL equal iRamDataOut. Read latency is 1 cycle; back-to-back reads SHALL sustain 1 read per cycle.
REQ-008 On a write grant, oRamWriteEnable SHALL be 1 in the same cycle, with the granted client's address and data on oRamWriteAddress and oRamDataIn. Otherwise oRamWriteEnable SHALL be 0.
REQ-009 A read and a write to the same address in the same cycle SHALL return the old RAM contents. No forwarding is done.
REQ-010 Arbitration SHALL be round-robin with separate last-winner pointers for read and for write. A pointer SHALL update only on a grant, and the winner SHALL lose the next tie.
REQ-011 With both clients requesting continuously, grants SHALL alternate 0,1,0,1 and no client SHALL wait more than 1 cycle.
REQ-012 With a single requester, that client SHALL be granted every cycle regardless of pointer state.

Reset
REQ-013 While Reset=1 the block SHALL drive the following:
- oReadGrant, oWriteGrant, oReadValid and oRamWriteEnable = 0
- oRamReadAddress, oRamWriteAddress and oRamDataIn = 0
- both pointers set so that client 0 wins the next tie
REQ-014 A read granted in the cycle before Reset asserts SHALL produce no oReadValid. Requests present during Reset SHALL be ignored and not queued.

Configuration
REQ-015 Macro RAM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy:
- defined: round-robin per REQ-010/011
- undefined: fixed priority, client 0 always wins ties, pointers removed, all other requirements unchanged

Structure
REQ-016 Package ram_arb_pkg SHALL hold the following:
- NUM_CLIENTS=2
- client-index constants CLIENT_0 and CLIENT_1
- the pointer type
REQ-017 One sub-module, rr_pick2, SHALL compute a one-hot grant from a 2-bit request and the pointer. It SHALL be instantiated twice (read and write).

Verification
REQ-018 Reset released, client 0 writes 8'hA5 to 10'h003 -> same cycle oWriteGrant=01, oRamWriteEnable=1, oRamWriteAddress=3, oRamDataIn=A5.
REQ-019 Client 1 reads 10'h003 after REQ-018 -> oReadGrant=10, next cycle oReadValid=10 and oReadData=A5.
REQ-020 Both clients request reads for 6 cycles -> grants 01,10,01,10,01,10, and each valid follows its grant by 1 cycle. With RAM_ARB_ROUND_ROBIN_EN undefined -> grants 01 for all 6 cycles.
REQ-021 Same cycle: client 0 writes 8'h3C to 10'h010 and client 1 reads 10'h010 (old contents 8'h00) -> read returns 00. A repeat read returns 3C.
REQ-022 Assert Reset in the cycle after a read grant -> no oReadValid. All outputs are 0 during reset, and after release client 0 wins the first tie.
